// File: rtl/demux_scan_ctrl_if.sv
// rtl/demux_scan_ctrl_if.sv - word handshake between upstream source and demux_scan_ctrl
interface demux_scan_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/demux_scan_ctrl.sv
// rtl/demux_scan_ctrl.sv - serialises an 8-bit word onto demux_1x8 data_in/sel, one channel per hold window
module demux_scan_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux_scan_ctrl_if.slave    up,
  input  logic                abort,
  output logic                data_in,
  output logic [2:0]          sel,
  output logic                busy,
  output logic                chan_strobe,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  logic [7:0]        word;
  logic [HOLD_W-1:0] cnt;
  logic [2:0]        sel_next;

  assign up.in_ready = (state == IDLE) && !rst;

  always_comb begin
    sel_next = sel + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word        <= 8'h00;
      cnt         <= '0;
      sel         <= 3'd0;
      data_in     <= 1'b0;
      busy        <= 1'b0;
      chan_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      chan_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (up.in_valid) begin
            state       <= SCAN;
            word        <= up.in_data;
            cnt         <= '0;
            sel         <= 3'd0;
            data_in     <= up.in_data[0];
            busy        <= 1'b1;
            chan_strobe <= 1'b1;
          end
        end
        SCAN: begin
          // abort wins over both channel advance and the exit to DONE
          if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= 3'd0;
            data_in <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (sel != 3'd7) begin
              sel         <= sel_next;
              data_in     <= word[sel_next];
              chan_strobe <= 1'b1;
            end else begin
              state   <= DONE;
              sel     <= 3'd0;
              data_in <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          sel     <= 3'd0;
          data_in <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb/tb_demux_scan_ctrl.sv - directed bench for demux_scan_ctrl with HOLD_CYCLES 4 and 1
module tb_demux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid_drv;
  logic [7:0] data_drv;
  logic       abort_drv;
  logic       use1;

  int errors = 0;
  int checks = 0;

  demux_scan_ctrl_if bus4();
  demux_scan_ctrl_if bus1();

  assign bus4.in_valid = valid_drv & ~use1;
  assign bus4.in_data  = data_drv;
  assign bus1.in_valid = valid_drv & use1;
  assign bus1.in_data  = data_drv;

  logic       a_data_in, a_busy, a_strobe, a_done;
  logic [2:0] a_sel;
  logic       b_data_in, b_busy, b_strobe, b_done;
  logic [2:0] b_sel;

  demux_scan_ctrl #(.HOLD_CYCLES(4), .HOLD_W(8)) dut4 (
    .clk(clk), .rst(rst), .up(bus4), .abort(abort_drv & ~use1),
    .data_in(a_data_in), .sel(a_sel), .busy(a_busy),
    .chan_strobe(a_strobe), .done(a_done)
  );

  demux_scan_ctrl #(.HOLD_CYCLES(1), .HOLD_W(8)) dut1 (
    .clk(clk), .rst(rst), .up(bus1), .abort(abort_drv & use1),
    .data_in(b_data_in), .sel(b_sel), .busy(b_busy),
    .chan_strobe(b_strobe), .done(b_done)
  );

  // obs = {sel, data_in, chan_strobe, done, busy, in_ready}
  logic [7:0] obs;
  always_comb begin
    obs = use1 ? {b_sel, b_data_in, b_strobe, b_done, b_busy, bus1.in_ready}
               : {a_sel, a_data_in, a_strobe, a_done, a_busy, bus4.in_ready};
  end

  localparam logic [7:0] IDLE_OBS = 8'b000_0_0_0_0_1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input string name, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] w, input bit keep_valid);
    int n = 0;
    valid_drv = 1'b1;
    data_drv  = w;
    while (!obs[0] && n < 200) begin
      step;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=in_ready_low exp=in_ready_high");
    end
    step;
    if (!keep_valid) valid_drv = 1'b0;
  endtask

  // Starts at the sample after the accepting edge; ends at the sample of the done cycle.
  task automatic scan_check(input string name, input logic [7:0] w, input int h, input int pulse_at);
    int strobes = 0;
    for (int k = 0; k <= 8*h; k++) begin
      logic [2:0] es;
      logic       ed, est, edn;
      if (k < 8*h) begin
        es  = 3'(k / h);
        ed  = w[k / h];
        est = ((k % h) == 0);
        edn = 1'b0;
      end else begin
        es = 3'd0; ed = 1'b0; est = 1'b0; edn = 1'b1;
      end
      checks++;
      if (obs !== {es, ed, est, edn, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s k=%0d got=%b exp=%b", name, k, obs, {es, ed, est, edn, 1'b1, 1'b0});
      end
      if (obs[3]) strobes++;
      if (pulse_at >= 0) begin
        valid_drv = (k == pulse_at);
        data_drv  = (k == pulse_at) ? 8'h3C : data_drv;
      end
      if (k < 8*h) step;
    end
    checks++;
    if (strobes != 8) begin
      errors++;
      $display("FAIL %s_strobes got=%0d exp=8", name, strobes);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_drv = 1'b0; data_drv = 8'h00; abort_drv = 1'b0; use1 = 1'b0;
    step; step;
    expect_obs("reset_dut4", 8'h00);
    use1 = 1'b1; #0;
    expect_obs("reset_dut1", 8'h00);
    use1 = 1'b0;
    rst = 1'b0;
    step;
    expect_obs("reset_release", IDLE_OBS);
  endtask

  task automatic test_scan_a5;
    accept(8'hA5, 1'b0);
    data_drv = 8'h5A;
    scan_check("scan_a5", 8'hA5, 4, -1);
    step;
    expect_obs("scan_a5_idle", IDLE_OBS);
  endtask

  task automatic test_back_to_back;
    accept(8'hFF, 1'b1);
    data_drv = 8'h00;
    scan_check("b2b_ff", 8'hFF, 4, -1);
    step;
    expect_obs("b2b_ready_return", IDLE_OBS);
    step;
    valid_drv = 1'b0;
    scan_check("b2b_00", 8'h00, 4, -1);
    step;
    expect_obs("b2b_idle", IDLE_OBS);
  endtask

  task automatic test_abort;
    int done_seen = 0;
    accept(8'hA5, 1'b0);
    repeat (13) step;
    expect_obs("abort_pre_sel3", 8'b011_0_0_0_1_0);
    abort_drv = 1'b1;
    step;
    abort_drv = 1'b0;
    expect_obs("abort_idle", IDLE_OBS);
    repeat (40) begin
      step;
      if (obs[2]) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d exp=0", done_seen);
    end
  endtask

  task automatic test_rst_mid_scan;
    int done_seen = 0;
    accept(8'hFF, 1'b0);
    repeat (21) step;
    expect_obs("rst_pre_sel5", 8'b101_1_0_0_1_0);
    rst = 1'b1;
    step;
    expect_obs("rst_mid_scan", 8'h00);
    step;
    expect_obs("rst_held", 8'h00);
    rst = 1'b0;
    #1;
    expect_obs("rst_release_ready", IDLE_OBS);
    repeat (40) begin
      step;
      if (obs[2]) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL rst_no_done got=%0d exp=0", done_seen);
    end
  endtask

  task automatic test_hold_one;
    use1 = 1'b1;
    #1;
    accept(8'h81, 1'b0);
    scan_check("hold1_81", 8'h81, 1, -1);
    step;
    expect_obs("hold1_idle", IDLE_OBS);
    use1 = 1'b0;
    #1;
  endtask

  task automatic test_valid_during_scan;
    accept(8'h5A, 1'b0);
    scan_check("ignore_3c", 8'h5A, 4, 10);
    valid_drv = 1'b0;
    step;
    expect_obs("ignore_idle", IDLE_OBS);
    step;
    expect_obs("ignore_not_stored", IDLE_OBS);
  endtask

  initial begin
    test_reset;
    test_scan_a5;
    test_back_to_back;
    test_abort;
    test_rst_mid_scan;
    test_hold_one;
    test_valid_during_scan;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
